gonso_multi_engine: RTL and testbench

Parametrised successor of the single-channel gonso register block. It is a Wishbone slave with NCH independent channels. Each channel holds an operand, step and iteration count, and one shared sequential engine computes result = operand + count*step per channel. Channels are serviced round-robin, completion is reported through per-channel done flags, and a level interrupt is raised to the Caravel user area.

---
 rtl/gonso_multi_pkg.sv | 27 ++
 rtl/gonso_multi_engine_if.sv | 26 ++
 rtl/gonso_multi_seq.sv | 86 ++++++++
 rtl/gonso_multi_engine.sv | 145 ++++++++++++++
 tb/tb_gonso_multi_engine.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/gonso_multi_pkg.sv
// gonso multi-channel engine: shared register map, state encoding and helpers.
// Imported by the register file and the sequencer.
package gonso_multi_pkg;

   localparam logic [31:0] GONSO_BASE_ADDR = 32'h3003_0000;

   localparam logic [7:0] CTRL      = 8'h00;
   localparam logic [7:0] STATUS    = 8'h04;
   localparam logic [7:0] START     = 8'h08;
   localparam logic [7:0] CH_BASE   = 8'h20;
   localparam logic [7:0] CH_STRIDE = 8'h10;

   localparam logic [3:0] OPERAND = 4'h0;
   localparam logic [3:0] STEP    = 4'h4;
   localparam logic [3:0] COUNT   = 4'h8;
   localparam logic [3:0] RESULT  = 4'hC;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } eng_state_t;

   function automatic logic [31:0] sel_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/gonso_multi_engine_if.sv
// Wishbone slave bundle for the gonso multi-channel engine.
// The master drives the request side, the slave returns data and ack.
interface gonso_multi_engine_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic [31:0] wishbone_address;
   logic        wbs_we_i;
   logic [31:0] wbs_dat_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wishbone_address,
      output wbs_we_i, wbs_dat_i, wbs_sel_i,
      input  wbs_dat_o, wbs_ack_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wishbone_address,
      input  wbs_we_i, wbs_dat_i, wbs_sel_i,
      output wbs_dat_o, wbs_ack_o
   );

endinterface

// File: rtl/gonso_multi_seq.sv
// Round-robin channel picker plus the shared accumulate engine.
// Works on latched copies so register writes only affect the next run.
module gonso_multi_seq
   import gonso_multi_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DSIZE = 32,
   parameter int CSIZE = 8,
   parameter int IW    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NCH-1:0]             pending,
   input  logic [NCH-1:0][DSIZE-1:0]  operand,
   input  logic [NCH-1:0][DSIZE-1:0]  step,
   input  logic [NCH-1:0][CSIZE-1:0]  count,
   output logic                       take,
   output logic [IW-1:0]              take_idx,
   output logic                       run,
   output logic [IW-1:0]              act,
   output logic                       res_we,
   output logic [IW-1:0]              res_idx,
   output logic [DSIZE-1:0]           res_val
);

   eng_state_t       state;
   logic [DSIZE-1:0] acc;
   logic [DSIZE-1:0] stp;
   logic [CSIZE-1:0] rem;
   logic [IW-1:0]    last;
   logic             found;

   // search starts one past the channel served last
   always_comb begin
      take_idx = '0;
      found    = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
         if (!found && pending[(int'(last) + k) % NCH]) begin
            found    = 1'b1;
            take_idx = IW'((int'(last) + k) % NCH);
         end
      end
   end

   assign take    = (state == S_IDLE) && en && found;
   assign run     = (state == S_RUN);
   assign res_we  = run && en && (rem == '0);
   assign res_idx = act;
   assign res_val = acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         acc   <= '0;
         stp   <= '0;
         rem   <= '0;
         act   <= '0;
         last  <= '0;
      end else if (!en) begin
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (found) begin
                  acc   <= operand[take_idx];
                  stp   <= step[take_idx];
                  rem   <= count[take_idx];
                  act   <= take_idx;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (rem != '0) begin
                  acc <= acc + stp;
                  rem <= rem - 1'b1;
               end else begin
                  last  <= act;
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/gonso_multi_engine.sv
// gonso multi-channel engine: Wishbone decode, register file and irq.
// The accumulate engine itself lives in gonso_multi_seq.
module gonso_multi_engine
   import gonso_multi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = GONSO_BASE_ADDR,
   parameter int          NCH       = 4,
   parameter int          DSIZE     = 32,
   parameter int          CSIZE     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   gonso_multi_engine_if.slave  wb,
   output logic                 irq
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   logic                      en, irq_en;
   logic [NCH-1:0]            pending, done, busy;
   logic [NCH-1:0]            pend_n, done_n, start_set, take_mask;
   logic [NCH-1:0]            clr_mask, set_mask;
   logic [NCH-1:0][DSIZE-1:0] operand, step, result;
   logic [NCH-1:0][CSIZE-1:0] count;

   logic             take, run, res_we;
   logic [IW-1:0]    take_idx, act, res_idx, ch;
   logic [DSIZE-1:0] res_val;

   logic        valid, wr;
   logic [31:0] off, wmask, rdata, wmerge;
   logic [7:0]  ch_off;
   logic        in_win, ch_hit;
   logic        hit_ctrl, hit_stat, hit_start;
   logic        hit_op, hit_step, hit_cnt, hit_res;

   assign valid  = wb.wbs_cyc_i & wb.wbs_stb_i;
   assign wr     = valid & ~wb.wbs_ack_o & wb.wbs_we_i;
   assign off    = wb.wishbone_address - BASE_ADDR;
   assign wmask  = sel_mask(wb.wbs_sel_i);
   assign in_win = (off[31:8] == 24'd0);
   assign ch_off = off[7:0] - CH_BASE;
   assign ch     = IW'(ch_off[7:4]);
   assign ch_hit = in_win && (off[7:0] >= CH_BASE)
                && (ch_off[7:4] < 4'(NCH));

   assign hit_ctrl  = in_win && (off[7:0] == CTRL);
   assign hit_stat  = in_win && (off[7:0] == STATUS);
   assign hit_start = in_win && (off[7:0] == START);
   assign hit_op    = ch_hit && (ch_off[3:0] == OPERAND);
   assign hit_step  = ch_hit && (ch_off[3:0] == STEP);
   assign hit_cnt   = ch_hit && (ch_off[3:0] == COUNT);
   assign hit_res   = ch_hit && (ch_off[3:0] == RESULT);

   always_comb begin
      for (int c = 0; c < NCH; c++)
         busy[c] = pending[c] | (run && act == IW'(c));
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         hit_ctrl: rdata[1:0] = {irq_en, en};
         hit_stat: begin
            rdata[NCH-1:0]  = busy;
            rdata[16+:NCH]  = done;
         end
         hit_op:   rdata[DSIZE-1:0] = operand[ch];
         hit_step: rdata[DSIZE-1:0] = step[ch];
         hit_cnt:  rdata[CSIZE-1:0] = count[ch];
         hit_res:  rdata[DSIZE-1:0] = result[ch];
         default:  rdata = '0;
      endcase
   end

   // byte-masked merge of the addressed register's current value
   assign wmerge = (rdata & ~wmask) | (wb.wbs_dat_i & wmask);

   always_comb begin
      start_set = '0;
      clr_mask  = '0;
      if (wr && hit_start && en)
         start_set = wb.wbs_dat_i[NCH-1:0] & wmask[NCH-1:0] & ~busy;
      if (wr && hit_stat)
         clr_mask = wb.wbs_dat_i[16+:NCH] & wmask[16+:NCH];
      take_mask = take ? (NCH'(1) << take_idx) : '0;
      set_mask  = res_we ? (NCH'(1) << res_idx) : '0;
      pend_n    = en ? ((pending & ~take_mask) | start_set) : '0;
      done_n    = (done & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_dat_o <= '0;
         en           <= 1'b0;
         irq_en       <= 1'b0;
         pending      <= '0;
         done         <= '0;
         operand      <= '0;
         step         <= '0;
         count        <= '0;
         result       <= '0;
         irq          <= 1'b0;
      end else begin
         if (valid && !wb.wbs_ack_o) begin
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= rdata;
         end else begin
            wb.wbs_ack_o <= 1'b0;
         end
         if (wr && hit_ctrl) {irq_en, en} <= wmerge[1:0];
         if (wr && hit_op)   operand[ch]  <= wmerge[DSIZE-1:0];
         if (wr && hit_step) step[ch]     <= wmerge[DSIZE-1:0];
         if (wr && hit_cnt)  count[ch]    <= wmerge[CSIZE-1:0];
         if (res_we)         result[res_idx] <= res_val;
         pending <= pend_n;
         done    <= done_n;
         irq     <= irq_en & (|done);
      end
   end

   gonso_multi_seq #(
      .NCH   (NCH),
      .DSIZE (DSIZE),
      .CSIZE (CSIZE),
      .IW    (IW)
   ) u_seq (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pending  (pending),
      .operand  (operand),
      .step     (step),
      .count    (count),
      .take     (take),
      .take_idx (take_idx),
      .run      (run),
      .act      (act),
      .res_we   (res_we),
      .res_idx  (res_idx),
      .res_val  (res_val)
   );

endmodule

// File: tb/tb_gonso_multi_engine.sv
// Directed bench for gonso_multi_engine: Wishbone register access,
// engine latency, round-robin order, abort, byte enables and reset.
module tb_gonso_multi_engine;

   localparam logic [31:0] B = 32'h3003_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] q;

   gonso_multi_engine_if wbi ();

   gonso_multi_engine #(
      .BASE_ADDR (B),
      .NCH       (4),
      .DSIZE     (32),
      .CSIZE     (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wbi.slave),
      .irq (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the commit edge
   task automatic xfer(input logic [31:0] off, input logic we,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r);
      int n;
      wbi.wbs_cyc_i        = 1'b1;
      wbi.wbs_stb_i        = 1'b1;
      wbi.wishbone_address = B + off;
      wbi.wbs_we_i         = we;
      wbi.wbs_dat_i        = d;
      wbi.wbs_sel_i        = s;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (wbi.wbs_ack_o !== 1'b1 && n < 20);
      if (wbi.wbs_ack_o !== 1'b1) begin
         errors++;
         $error("FAIL ack_timeout: got no ack at offset %h", off);
      end
      r = wbi.wbs_dat_o;
      wbi.wbs_cyc_i = 1'b0;
      wbi.wbs_stb_i = 1'b0;
      wbi.wbs_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      xfer(off, 1'b1, d, 4'hF, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] off,
                         input logic [31:0] exp);
      logic [31:0] r;
      xfer(off, 1'b0, 32'h0, 4'hF, r);
      check(tag, r, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wbi.wbs_cyc_i        = 1'b0;
      wbi.wbs_stb_i        = 1'b0;
      wbi.wishbone_address = '0;
      wbi.wbs_we_i         = 1'b0;
      wbi.wbs_dat_i        = '0;
      wbi.wbs_sel_i        = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      check("rst_irq", {31'd0, irq}, 32'd0);
      rd_chk("rst_ctrl", 32'h00, 32'h0);
      rd_chk("rst_status", 32'h04, 32'h0);
      rd_chk("rst_start", 32'h08, 32'h0);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            rd_chk($sformatf("rst_ch%0d_r%0d", c, r),
                   32'h20 + 32'(16 * c + 4 * r), 32'h0);
      rd_chk("unmapped_1c", 32'h1C, 32'h0);

      // basic run: 10 + 4*5
      wr(32'h00, 32'h3);
      wr(32'h20, 32'd10);
      wr(32'h24, 32'd5);
      wr(32'h28, 32'd4);
      wr(32'h08, 32'h1);
      repeat (6) @(negedge clk);
      check("irq_before", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_after", {31'd0, irq}, 32'd1);
      rd_chk("done0", 32'h04, 32'h0001_0000);
      rd_chk("result0", 32'h2C, 32'd30);
      wr(32'h04, 32'h0001_0000);
      @(negedge clk);
      check("irq_w1c", {31'd0, irq}, 32'd0);
      rd_chk("status_w1c", 32'h04, 32'h0);

      // wrap-around
      wr(32'h20, 32'hFFFF_FFFE);
      wr(32'h24, 32'd3);
      wr(32'h28, 32'd1);
      wr(32'h08, 32'h1);
      repeat (8) @(negedge clk);
      rd_chk("wrap_result", 32'h2C, 32'd1);
      wr(32'h04, 32'h0001_0000);

      // zero count on ch3
      wr(32'h50, 32'd7);
      wr(32'h54, 32'd9);
      wr(32'h58, 32'd0);
      wr(32'h08, 32'h8);
      repeat (2) @(negedge clk);
      check("zc_irq_before", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("zc_irq_after", {31'd0, irq}, 32'd1);
      rd_chk("zc_result3", 32'h5C, 32'd7);
      wr(32'h04, 32'h0008_0000);

      // round-robin, every channel COUNT=2
      wr(32'h30, 32'd100);
      wr(32'h34, 32'd7);
      wr(32'h40, 32'h1000);
      wr(32'h44, 32'h10);
      wr(32'h28, 32'd2);
      wr(32'h38, 32'd2);
      wr(32'h48, 32'd2);
      wr(32'h58, 32'd2);
      wr(32'h08, 32'hF);
      wr(32'h08, 32'h3);
      rd_chk("rr_e4", 32'h04, 32'h0000_000F);
      rd_chk("rr_e6", 32'h04, 32'h0001_000E);
      rd_chk("rr_e8", 32'h04, 32'h0001_000E);
      rd_chk("rr_e10", 32'h04, 32'h0003_000C);
      rd_chk("rr_e12", 32'h04, 32'h0003_000C);
      rd_chk("rr_e14", 32'h04, 32'h0007_0008);
      rd_chk("rr_e16", 32'h04, 32'h0007_0008);
      rd_chk("rr_e18", 32'h04, 32'h000F_0000);
      rd_chk("rr_res0", 32'h2C, 32'd4);
      rd_chk("rr_res1", 32'h3C, 32'd114);
      rd_chk("rr_res2", 32'h4C, 32'h1020);
      rd_chk("rr_res3", 32'h5C, 32'd25);
      wr(32'h04, 32'h000F_0000);

      // abort a long run on ch2
      wr(32'h48, 32'd200);
      wr(32'h08, 32'h4);
      repeat (8) @(negedge clk);
      wr(32'h00, 32'h2);
      repeat (2) @(negedge clk);
      rd_chk("abort_status", 32'h04, 32'h0);
      rd_chk("abort_result2", 32'h4C, 32'h1020);
      rd_chk("abort_ctrl", 32'h00, 32'h2);
      check("abort_irq", {31'd0, irq}, 32'd0);
      wr(32'h08, 32'h4);
      rd_chk("dis_start", 32'h04, 32'h0);
      wr(32'h00, 32'h3);
      repeat (4) @(negedge clk);
      rd_chk("reen_status", 32'h04, 32'h0);

      // byte enables
      wr(32'h30, 32'h0);
      begin
         logic [31:0] dummy;
         xfer(32'h30, 1'b1, 32'hAABB_CCDD, 4'b0101, dummy);
      end
      rd_chk("sel_0101", 32'h30, 32'h00BB_00DD);

      // asynchronous reset in the middle of a run
      wr(32'h08, 32'h8);
      repeat (6) @(negedge clk);
      check("pre_rst_irq", {31'd0, irq}, 32'd1);
      wr(32'h38, 32'd200);
      wr(32'h08, 32'h2);
      rd_chk("pre_rst_res3", 32'h5C, 32'd25);
      check("pre_rst_dat", wbi.wbs_dat_o, 32'd25);
      #2 rst = 1'b1;
      #1;
      check("async_irq", {31'd0, irq}, 32'd0);
      check("async_dat", wbi.wbs_dat_o, 32'd0);
      check("async_ack", {31'd0, wbi.wbs_ack_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("post_rst_status", 32'h04, 32'h0);
      rd_chk("post_rst_ctrl", 32'h00, 32'h0);
      rd_chk("post_rst_res3", 32'h5C, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
